// File: rtl/ysyx_23060201_lsu_if.sv
// ysyx_23060201_lsu_if: EXU request, WBU response and data-memory port of the LSU.
// The LSU takes the slave side; the EXU/WBU/memory environment takes the master side.
interface ysyx_23060201_lsu_if #(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic req_valid;
    logic req_ready;
    logic req_wen;
    logic [2:0] req_funct3;
    logic [MEM_ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic resp_valid;
    logic resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic resp_err;
    logic mem_ren;
    logic [MEM_ADDR_WIDTH-1:0] mem_raddr;
    logic [7:0] mem_rmask;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic mem_wen;
    logic [MEM_ADDR_WIDTH-1:0] mem_waddr;
    logic [7:0] mem_wmask;
    logic [DATA_WIDTH-1:0] mem_wdata;
    modport slave (
        input req_valid, req_wen, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_ren, mem_raddr, mem_rmask, mem_wen, mem_waddr, mem_wmask, mem_wdata
    );
    modport master (
        output req_valid, req_wen, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        input req_ready, resp_valid, resp_rdata, resp_err,
        input mem_ren, mem_raddr, mem_rmask, mem_wen, mem_waddr, mem_wmask, mem_wdata
    );
endinterface

// File: rtl/ysyx_23060201_lsu.sv
// ysyx_23060201_lsu: RV32 load/store unit driving a single-cycle, word-wide data-memory port.
// One op at a time: IDLE -> ACCESS -> RESP, illegal requests skip straight to RESP.
module ysyx_23060201_lsu #(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic clk,
    input logic rst,
    ysyx_23060201_lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state;
    logic wen_q;
    logic [2:0] funct3_q;
    logic [1:0] off_q;
    logic [1:0] off;
    logic illegal;
    logic [3:0] mask;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] ext;
    logic [MEM_ADDR_WIDTH-1:0] word_addr;
    assign bus.req_ready = state == IDLE;
    assign off = bus.req_addr[1:0];
    assign word_addr = {bus.req_addr[MEM_ADDR_WIDTH-1:2], 2'b00};
    always_comb begin
        illegal = bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11
               || (bus.req_wen && bus.req_funct3[2])
               || (bus.req_funct3[1:0] == 2'b01 && off[0])
               || (bus.req_funct3[1:0] == 2'b10 && off != 2'b00);
        mask = bus.req_funct3[1:0] == 2'b00 ? 4'b0001 << off :
               bus.req_funct3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
        data = bus.mem_rdata >> {off_q, 3'b000};
        ext = funct3_q == 3'b000 ? {{(DATA_WIDTH-8){data[7]}}, data[7:0]} :
              funct3_q == 3'b100 ? {{(DATA_WIDTH-8){1'b0}}, data[7:0]} :
              funct3_q == 3'b001 ? {{(DATA_WIDTH-16){data[15]}}, data[15:0]} :
              funct3_q == 3'b101 ? {{(DATA_WIDTH-16){1'b0}}, data[15:0]} : data;
    end
    // Memory strobes are registers so an async reset kills an in-flight write before its edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            wen_q <= 1'b0;
            funct3_q <= '0;
            off_q <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err <= 1'b0;
            bus.mem_ren <= 1'b0;
            bus.mem_wen <= 1'b0;
            bus.mem_raddr <= '0;
            bus.mem_waddr <= '0;
            bus.mem_rmask <= '0;
            bus.mem_wmask <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    wen_q <= bus.req_wen;
                    funct3_q <= bus.req_funct3;
                    off_q <= off;
                    if (illegal) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_err <= 1'b1;
                        bus.resp_rdata <= '0;
                        state <= RESP;
                    end else begin
                        bus.mem_ren <= !bus.req_wen;
                        bus.mem_wen <= bus.req_wen;
                        bus.mem_raddr <= word_addr;
                        bus.mem_waddr <= word_addr;
                        bus.mem_rmask <= {4'b0000, mask};
                        bus.mem_wmask <= {4'b0000, mask};
                        bus.mem_wdata <= bus.req_wdata << {off, 3'b000};
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    bus.mem_ren <= 1'b0;
                    bus.mem_wen <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    bus.resp_err <= 1'b0;
                    bus.resp_rdata <= wen_q ? '0 : ext;
                    state <= RESP;
                end
                RESP: if (bus.resp_ready) begin
                    bus.resp_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
